// File: rtl/ser_tx_if.sv
// ser_tx_if: word handshake between a word producer and the ser_tx serializer.
//   in_data  : word to transmit (producer -> serializer)
//   in_valid : in_data holds a word (producer -> serializer)
//   in_ready : serializer can take a word this cycle (serializer -> producer)
// master modport is the producer side, slave modport is the serializer side.
interface ser_tx_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ser_tx.sv
// ser_tx: parallel-to-serial transmitter feeding the "101" detector path.
// Words arrive on a valid/ready handshake, go out MSB first on `out`, and
// each word is followed by GAP forced-0 line cycles. The block also watches
// its own line and pulses `hit` exactly as a Moore "101" detector tied to
// `out` would, with a saturating hit counter alongside.
//
// Ports:
//   clk      : clock, rising edge
//   rstn     : asynchronous active-low reset
//   s_in     : ser_tx_if slave (in_data, in_valid in; in_ready out)
//   clr_cnt  : synchronous clear of hit_cnt (wins over an increment)
//   out      : serial line, idles at 0
//   busy     : a word or its gap is in progress
//   hit      : one-cycle pulse the cycle after the line completed "101"
//   hit_cnt  : saturating count of hits
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | line at 0, ready for a word
// ST_SHIFT | driving sh MSB, bit_cnt counts bits already sent
// ST_GAP   | forced-0 gap after a word, gap_cnt counts gap cycles
module ser_tx #(
   parameter int WIDTH = 8,
   parameter int GAP   = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rstn,
   ser_tx_if.slave          s_in,
   input  logic             clr_cnt,
   output logic             out,
   output logic             busy,
   output logic             hit,
   output logic [CNT_W-1:0] hit_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam int BW = $clog2(WIDTH);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   state_t           r_state;
   logic [WIDTH-1:0] r_sh;
   logic [BW-1:0]    r_bit_cnt;
   logic [GW-1:0]    r_gap_cnt;
   logic             r_out;
   logic             r_in_ready;
   logic             r_busy;
   logic [1:0]       r_hist;
   logic             r_hit;
   logic [CNT_W-1:0] r_hit_cnt;

   state_t           w_state_nx;
   logic [WIDTH-1:0] w_sh_nx;
   logic [BW-1:0]    w_bit_nx;
   logic [GW-1:0]    w_gap_nx;
   logic             w_accept;
   logic             w_out_nx;
   logic             w_ready_nx;
   logic             w_hit_nx;

   always_comb begin
      w_accept   = s_in.in_valid && r_in_ready;
      w_state_nx = r_state;
      w_sh_nx    = r_sh;
      w_bit_nx   = r_bit_cnt;
      w_gap_nx   = r_gap_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nx = ST_SHIFT;
               w_sh_nx    = s_in.in_data;
               w_bit_nx   = '0;
            end
         end
         ST_SHIFT: begin
            w_sh_nx  = r_sh << 1;
            w_bit_nx = r_bit_cnt + 1'b1;
            if (r_bit_cnt == BIT_LAST) begin
               if (GAP > 0) begin
                  w_state_nx = ST_GAP;
                  w_gap_nx   = '0;
               end else if (w_accept) begin
                  w_sh_nx  = s_in.in_data;
                  w_bit_nx = '0;
               end else begin
                  w_state_nx = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            w_gap_nx = r_gap_cnt + 1'b1;
            if (r_gap_cnt == GAP_LAST) begin
               if (w_accept) begin
                  w_state_nx = ST_SHIFT;
                  w_sh_nx    = s_in.in_data;
                  w_bit_nx   = '0;
               end else begin
                  w_state_nx = ST_IDLE;
               end
            end
         end
         default: w_state_nx = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they never follow
      // in_valid combinationally. Ready covers idle and the final cycle of
      // a frame so back-to-back words leave no bubble on the line.
      w_out_nx   = (w_state_nx == ST_SHIFT) && w_sh_nx[WIDTH-1];
      w_ready_nx = (w_state_nx == ST_IDLE)
                || ((w_state_nx == ST_SHIFT) && (GAP == 0) && (w_bit_nx == BIT_LAST))
                || ((w_state_nx == ST_GAP) && (w_gap_nx == GAP_LAST));

      // hist holds the two cycles before the current line bit.
      w_hit_nx = (r_hist == 2'b10) && r_out;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_sh       <= '0;
         r_bit_cnt  <= '0;
         r_gap_cnt  <= '0;
         r_out      <= 1'b0;
         r_in_ready <= 1'b1;
         r_busy     <= 1'b0;
         r_hist     <= 2'b00;
         r_hit      <= 1'b0;
         r_hit_cnt  <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_sh       <= w_sh_nx;
         r_bit_cnt  <= w_bit_nx;
         r_gap_cnt  <= w_gap_nx;
         r_out      <= w_out_nx;
         r_in_ready <= w_ready_nx;
         r_busy     <= (w_state_nx != ST_IDLE);
         r_hist     <= {r_hist[0], r_out};
         r_hit      <= w_hit_nx;
         if (clr_cnt) begin
            r_hit_cnt <= '0;
         end else if (w_hit_nx && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
         end
      end
   end

   assign s_in.in_ready = r_in_ready;
   assign out           = r_out;
   assign busy          = r_busy;
   assign hit           = r_hit;
   assign hit_cnt       = r_hit_cnt;

endmodule

// File: tb/tb_ser_tx.sv
// tb_ser_tx: bench for ser_tx. Three instances (GAP=2, GAP=0, CNT_W=2) share
// clk/rstn; `sel` picks the one being driven and observed. A line model
// queues expected bits when a word is accepted and pops one per cycle; a
// Moore "101" detector tied to the observed line provides the expected hit.
module tb_ser_tx;

   logic       clk;
   logic       rstn;
   int         sel;
   logic       v_valid;
   logic [7:0] v_data;
   logic       v_clr;
   bit         chk_en;
   int         tests;
   int         fails;

   ser_tx_if #(.WIDTH(8)) if_a ();
   ser_tx_if #(.WIDTH(8)) if_b ();
   ser_tx_if #(.WIDTH(8)) if_c ();

   logic        out_a, busy_a, hit_a;
   logic        out_b, busy_b, hit_b;
   logic        out_c, busy_c, hit_c;
   logic [15:0] cnt_a, cnt_b;
   logic [1:0]  cnt_c;
   logic        clr_a, clr_b, clr_c;

   assign if_a.in_valid = (sel == 0) && v_valid;
   assign if_b.in_valid = (sel == 1) && v_valid;
   assign if_c.in_valid = (sel == 2) && v_valid;
   assign if_a.in_data  = v_data;
   assign if_b.in_data  = v_data;
   assign if_c.in_data  = v_data;
   assign clr_a = (sel == 0) && v_clr;
   assign clr_b = (sel == 1) && v_clr;
   assign clr_c = (sel == 2) && v_clr;

   ser_tx #(.WIDTH(8), .GAP(2), .CNT_W(16)) dut_a (
      .clk(clk), .rstn(rstn), .s_in(if_a), .clr_cnt(clr_a),
      .out(out_a), .busy(busy_a), .hit(hit_a), .hit_cnt(cnt_a));
   ser_tx #(.WIDTH(8), .GAP(0), .CNT_W(16)) dut_b (
      .clk(clk), .rstn(rstn), .s_in(if_b), .clr_cnt(clr_b),
      .out(out_b), .busy(busy_b), .hit(hit_b), .hit_cnt(cnt_b));
   ser_tx #(.WIDTH(8), .GAP(2), .CNT_W(2)) dut_c (
      .clk(clk), .rstn(rstn), .s_in(if_c), .clr_cnt(clr_c),
      .out(out_c), .busy(busy_c), .hit(hit_c), .hit_cnt(cnt_c));

   logic        w_out, w_rdy, w_busy, w_hit;
   logic [15:0] w_cnt;
   assign w_out  = (sel == 0) ? out_a       : (sel == 1) ? out_b       : out_c;
   assign w_rdy  = (sel == 0) ? if_a.in_ready : (sel == 1) ? if_b.in_ready : if_c.in_ready;
   assign w_busy = (sel == 0) ? busy_a      : (sel == 1) ? busy_b      : busy_c;
   assign w_hit  = (sel == 0) ? hit_a       : (sel == 1) ? hit_b       : hit_c;
   assign w_cnt  = (sel == 0) ? cnt_a       : (sel == 1) ? cnt_b       : {14'd0, cnt_c};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int gap_of(int s);
      return (s == 1) ? 0 : 2;
   endfunction

   function automatic void chk(string nm, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endfunction

   // Line model / scoreboard and reference detector.
   bit q[$];
   int det;
   int m_cnt;
   bit acc;
   bit lb;
   initial begin
      det   = 0;
      m_cnt = 0;
      forever begin
         @(posedge clk or negedge rstn);
         if (!rstn) begin
            q.delete();
            det   = 0;
            m_cnt = 0;
         end else begin
            acc = v_valid && (q.size() <= 1);
            lb  = w_out;
            if (q.size() > 0) void'(q.pop_front());
            if (acc) begin
               for (int i = 7; i >= 0; i--) q.push_back(v_data[i]);
               for (int g = 0; g < gap_of(sel); g++) q.push_back(1'b0);
            end
            case (det)
               0:       det = lb ? 1 : 0;
               1:       det = lb ? 1 : 2;
               2:       det = lb ? 3 : 0;
               default: det = lb ? 1 : 2;
            endcase
            if (v_clr) m_cnt = 0;
            else if (det == 3 && m_cnt < ((sel == 2) ? 3 : 65535)) m_cnt++;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            chk("sb_out",   int'(w_out),  (q.size() > 0) ? int'(q[0]) : 0);
            chk("sb_ready", int'(w_rdy),  (q.size() <= 1) ? 1 : 0);
            chk("sb_busy",  int'(w_busy), (q.size() > 0) ? 1 : 0);
            chk("sb_hit",   int'(w_hit),  (det == 3) ? 1 : 0);
            chk("sb_cnt",   int'(w_cnt),  m_cnt);
         end
      end
   end

   task automatic reset_sel(int s);
      v_valid = 1'b0;
      v_clr   = 1'b0;
      @(negedge clk);
      #2 rstn = 1'b0;
      sel = s;
      @(negedge clk);
      #2 rstn = 1'b1;
   endtask

   task automatic rand_run(int s, int n);
      reset_sel(s);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         v_valid = ($urandom_range(0, 3) != 0);
         v_data  = 8'($urandom);
         v_clr   = ($urandom_range(0, 63) == 0);
         if (!rstn) #2 rstn = 1'b1;
         else if ($urandom_range(0, 399) == 0) #2 rstn = 1'b0;
      end
      @(negedge clk);
      v_valid = 1'b0;
      v_clr   = 1'b0;
      #2 rstn = 1'b1;
   endtask

   typedef struct {
      int          sel;
      logic [7:0]  w0;
      logic [7:0]  w1;
      bit          two;
      int          len;
      logic [31:0] line;
      logic [31:0] hits;
      int          cnt;
   } vec_t;

   vec_t        tbl [6];
   logic [31:0] cap_l, cap_h;
   int          frame;

   initial begin
      tbl[0] = '{0, 8'hA5, 8'h00, 1'b0, 10, 32'b10100101_00, 32'b00010000_10, 2};
      tbl[1] = '{0, 8'hFF, 8'h55, 1'b1, 20, 32'b11111111_00_01010101_00,
                 32'b00000000_00_00001010_10, 3};
      tbl[2] = '{1, 8'h05, 8'h40, 1'b1, 16, 32'b00000101_01000000,
                 32'b00000000_10100000, 2};
      tbl[3] = '{2, 8'h55, 8'h55, 1'b1, 20, 32'b01010101_00_01010101_00,
                 32'b00001010_10_00001010_10, 3};
      tbl[4] = '{0, 8'h00, 8'h00, 1'b0, 10, 32'd0, 32'd0, 0};
      tbl[5] = '{1, 8'hB5, 8'h00, 1'b0, 10, 32'b10110101_00, 32'b00010010_10, 3};

      tests   = 0;
      fails   = 0;
      chk_en  = 1'b0;
      sel     = 0;
      v_valid = 1'b0;
      v_data  = 8'h00;
      v_clr   = 1'b0;
      rstn    = 1'b1;
      #1 rstn = 1'b0;
      #1;
      chk("rst_out",   int'(out_a),        0);
      chk("rst_ready", int'(if_a.in_ready), 1);
      chk("rst_busy",  int'(busy_a),       0);
      chk("rst_hit",   int'(hit_a),        0);
      chk("rst_cnt",   int'(cnt_a),        0);
      @(negedge clk);
      #2 rstn = 1'b1;
      chk_en = 1'b1;

      for (int t = 0; t < 6; t++) begin
         reset_sel(tbl[t].sel);
         @(negedge clk);
         v_data  = tbl[t].w0;
         v_valid = 1'b1;
         cap_l   = '0;
         cap_h   = '0;
         frame   = 8 + gap_of(tbl[t].sel);
         for (int c = 1; c <= tbl[t].len; c++) begin
            @(negedge clk);
            cap_l = {cap_l[30:0], w_out};
            cap_h = {cap_h[30:0], w_hit};
            if (c == 1) v_data = tbl[t].w1;
            if (!tbl[t].two || c == frame + 1) v_valid = 1'b0;
         end
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d_line", t), int'(cap_l), int'(tbl[t].line));
         chk($sformatf("vec%0d_hits", t), int'(cap_h), int'(tbl[t].hits));
         chk($sformatf("vec%0d_cnt",  t), int'(w_cnt), tbl[t].cnt);
      end

      // Clear coincident with a hit: the pulse survives, the count does not.
      reset_sel(2);
      @(negedge clk);
      v_data  = 8'hA5;
      v_valid = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) v_valid = 1'b0;
         if (c == 3) v_clr = 1'b1;
         if (c == 4) begin
            v_clr = 1'b0;
            chk("clr_hit_pulse", int'(w_hit), 1);
            chk("clr_cnt_zero",  int'(w_cnt), 0);
         end
         if (c == 10) chk("clr_cnt_after", int'(w_cnt), 1);
      end

      // Reset in the middle of a word while the line is high.
      reset_sel(0);
      @(negedge clk);
      v_data  = 8'hA5;
      v_valid = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) v_valid = 1'b0;
      end
      chk("pre_rst_out", int'(w_out), 1);
      chk("pre_rst_cnt", int'(w_cnt), 1);
      #2 rstn = 1'b0;
      #1;
      chk("mid_rst_out",   int'(w_out),  0);
      chk("mid_rst_ready", int'(w_rdy),  1);
      chk("mid_rst_busy",  int'(w_busy), 0);
      chk("mid_rst_hit",   int'(w_hit),  0);
      chk("mid_rst_cnt",   int'(w_cnt),  0);
      @(negedge clk);
      #2 rstn = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("post_rst_line", int'(w_out), 0);
         chk("post_rst_hit",  int'(w_hit), 0);
      end

      rand_run(0, 10000);
      rand_run(1, 3000);
      rand_run(2, 3000);

      @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ser_tx.md
# ser_tx

Parallel-to-serial bit transmitter that sources the single-bit serial stream consumed by the "101" sequence detector. It accepts WIDTH-bit words over a valid/ready handshake, shifts them out MSB first with a fixed zero-gap between words, and independently reports every "101" pattern it places on the line. Its `hit` output is defined to match, cycle for cycle, the detector's output when both share clock and reset. It serves as the stimulus source and scoreboard reference for the detector path.

## Interface
- `WIDTH`, default 8: data word width in bits, must be ≥ 2.
- `GAP`, default 2: number of forced-0 line cycles after each word, must be ≥ 0.
- `CNT_W`, default 16: width of the hit counter.

- `clk`  input  1: clock, all state updates on rising edge.
- `rstn`  input  1: reset, asynchronous, active-low.
- `in_data`  input  WIDTH: word to transmit, sampled on accept.
- `in_valid`  input  1: `in_data` is valid.
- `in_ready`  output  1: block can accept a word this cycle.
- `clr_cnt`  input  1: synchronous clear of `hit_cnt`.
- `out`  output  1: serial line, idles at 0.
- `busy`  output  1: a word or its gap is in progress (SHIFT or GAP).
- `hit`  output  1: one-cycle pulse, registered, the cycle after the line completed "101".
- `hit_cnt`  output  CNT_W: saturating count of hits since reset or clear.

## Operation
- Accept occurs on a rising edge when `in_valid && in_ready`. `in_data` is loaded into shift register `sh`.
- FSM states:
  - IDLE: `out`=0, `in_ready`=1.
  - SHIFT: `out`=`sh[WIDTH-1]`.
  - GAP: `out`=0.
- `out` and `in_ready` are decoded from registered state only. They never depend combinationally on `in_valid`.
- IDLE → SHIFT on accept, with `bit_cnt`←0.
- In SHIFT, each edge does `sh`←`sh<<1` and `bit_cnt`++.
- When `bit_cnt`==WIDTH-1:
  - if GAP>0: go to GAP with `gap_cnt`←0;
  - if GAP==0: on accept reload and stay in SHIFT with `bit_cnt`←0, otherwise go to IDLE.
- In GAP, `gap_cnt`++ each edge. When `gap_cnt`==GAP-1: on accept go to SHIFT with reload, otherwise go to IDLE.
- `in_ready` is 1 in IDLE and in the final cycle of a frame: the last gap bit, or the last data bit when GAP==0. It is 0 otherwise.
- `busy` = (state != IDLE).
- History `hist[1:0]` updates on every edge in every state as `hist`←{`hist[0]`, `out`}. This includes idle and gap zeros, so the hist register tracks the line exactly.
- On every edge, `hit`←(`hist`==2'b10 && `out`==1). Overlapping occurrences count, e.g. "10101" gives two hits.
- `hit_cnt` increments on the same edge that sets `hit`, and saturates at all-ones.
- If `clr_cnt` is 1 on an edge, `hit_cnt`←0. This wins over a coincident increment.
- `clr_cnt` does not affect `hit` or `hist`.

## Timing
- Reset (async, immediate):
  - state=IDLE, `sh`=0, counters=0, `hist`=00;
  - `out`=0, `in_ready`=1, `busy`=0, `hit`=0, `hit_cnt`=0.
- An `rstn` assertion mid-word or mid-gap discards the word. The line drops to 0 immediately, and no hit is produced from partial history.
- Latency: for an accept at edge k, bit i (MSB=0) is on `out` during cycle k+1+i.
- Gap cycles occupy k+1+WIDTH … k+WIDTH+GAP.
- Sustained throughput is one word per WIDTH+GAP cycles, with no bubble when `in_valid` is held.
- `hit` is high during the cycle after the cycle whose `out` completed "101". This equals the detector's Moore output timing when the detector's input is tied to `out`.
- `in_data` is don't-care when not accepted. A new word is never accepted while `in_ready`=0.

## Test plan
- **Reset values:** assert `rstn`=0 mid-run.
  - Required: immediately `out`=0, `in_ready`=1, `busy`=0, `hit`=0, `hit_cnt`=0.
  - Required after release: the line stays 0 and no hit occurs.
- **Single word** (WIDTH=8, GAP=2): send 0xA5.
  - Required: `out`=1,0,1,0,0,1,0,1 in cycles 1–8 after accept, then 0,0.
  - Required: `hit` high in cycles 4 and 9, then `hit_cnt`=2, `in_ready` high in cycle 10.
- **Back-to-back** (GAP=2): hold `in_valid` with 0xFF then 0x55.
  - Required: second accept at the edge ending cycle 10, with first 0x55 bit in cycle 11 and no idle cycle.
  - Required: 0xFF yields no hits, 0x55 yields 3; final `hit_cnt`=3.
- **Cross-word pattern** (GAP=0): send 0x05 then 0x40 back to back.
  - Required: line reads 0000010101000000.
  - Required: 2 hits, one spanning the word boundary; `in_ready` high on each last data bit.
- **Counter rules** (CNT_W=2): stream 0x55 to produce 4+ hits.
  - Required: `hit_cnt` saturates at 3.
  - Required: `clr_cnt` on the same edge as a hit leaves `hit_cnt`=0 while `hit` still pulses.
- **Detector cross-check:** random words and random `in_valid`, with the detector's input tied to `out` and shared clk/rstn.
  - Required: detector output equals `hit` on every cycle for ≥10,000 cycles, including resets mid-word.
